// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states, frame limits and parity encodings for the UART receive engine.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_e;
    localparam int MIN_DATA_BITS = 5;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int max_bits);
        return bits < 4'(MIN_DATA_BITS) ? 4'(MIN_DATA_BITS) : bits > 4'(max_bits) ? 4'(max_bits) : bits;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received word with per-frame flags behind a valid/ready holding register.
interface uart_rx_if #(parameter int MAX_DATA_BITS = 9);
    logic [MAX_DATA_BITS-1:0] data_o;
    logic valid_o;
    logic ready_i;
    logic parity_err_o;
    logic frame_err_o;
    logic break_o;
    logic overrun_o;
    modport master(output data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o, input ready_i);
    modport slave(input data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o, output ready_i);
endinterface

// File: rtl/synchronizer.sv
// synchronizer: 2-flop metastability guard, resets to the idle-high line level.
module synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversample tick counter with three-sample majority vote around mid-bit.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    input  logic rx,
    output logic bit_valid,
    output logic bit_value
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2);
    logic [CW-1:0] cnt;
    logic s0, s1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            s0  <= 1'b1;
            s1  <= 1'b1;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt == CW'(OVERSAMPLE - 1) ? '0 : cnt + 1'b1;
            if (cnt == MID - 1'b1) s0 <= rx;
            if (cnt == MID) s1 <= rx;
        end
    end
    // Third sample is taken live so the decision lands in the same clk as its tick.
    assign bit_valid = tick && !clear && cnt == MID + 1'b1;
    assign bit_value = (s0 & s1) | (s0 & rx) | (s1 & rx);
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receive FSM with shifter, parity/frame/break detection
// and a valid/ready holding register that flags overruns.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en_i,
    input  logic       tick_i,
    input  logic       rx_i,
    input  logic [3:0] data_bits_i,
    input  logic       parity_en_i,
    input  logic       parity_type_i,
    input  logic       stop_bits_i,
    output logic       busy_o,
    uart_rx_if.master  rx_bus
);
    rx_state_e state, state_n;
    logic rx_s, rx_q, start_edge;
    logic bit_valid, bit_value;
    logic start, done, load, last_bit;
    logic [3:0] nbits, bit_cnt;
    logic par_en, par_type, two_stop;
    logic [MAX_DATA_BITS-1:0] sh;
    logic par_acc, ferr, any_one;

    synchronizer u_sync (.clk(clk), .reset(reset), .d(rx_i), .q(rx_s));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_q <= 1'b1;
        else rx_q <= rx_s;
    end
    assign start_edge = rx_q & ~rx_s;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk(clk), .reset(reset), .clear(start), .tick(tick_i), .rx(rx_s),
        .bit_valid(bit_valid), .bit_value(bit_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= state_n;
            busy_o <= state_n != IDLE;
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = start ? START : IDLE;
        else if (!rx_en_i) state_n = IDLE;
        else if (bit_valid)
            case (state)
                START:   state_n = bit_value ? IDLE : DATA;
                DATA:    state_n = last_bit ? (par_en ? PARITY : STOP1) : DATA;
                PARITY:  state_n = STOP1;
                STOP1:   state_n = two_stop ? STOP2 : IDLE;
                default: state_n = IDLE;
            endcase
    end

    always_comb begin
        start    = state == IDLE && rx_en_i && start_edge;
        last_bit = bit_cnt == nbits - 4'd1;
        done     = bit_valid && rx_en_i && (state == STOP2 || (state == STOP1 && !two_stop));
        load     = done && (!rx_bus.valid_o || rx_bus.ready_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nbits    <= 4'(MIN_DATA_BITS);
            par_en   <= 1'b0;
            par_type <= PARITY_EVEN;
            two_stop <= 1'b0;
            bit_cnt  <= '0;
            sh       <= '0;
            par_acc  <= 1'b0;
            ferr     <= 1'b0;
            any_one  <= 1'b0;
        end else if (start) begin
            nbits    <= clamp_bits(data_bits_i, MAX_DATA_BITS);
            par_en   <= parity_en_i;
            par_type <= parity_type_i;
            two_stop <= stop_bits_i;
            bit_cnt  <= '0;
            sh       <= '0;
            par_acc  <= 1'b0;
            ferr     <= 1'b0;
            any_one  <= 1'b0;
        end else if (bit_valid && state != IDLE) begin
            any_one <= any_one | bit_value;
            if (state == DATA) begin
                sh      <= sh | (MAX_DATA_BITS'(bit_value) << bit_cnt);
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == DATA || state == PARITY) par_acc <= par_acc ^ bit_value;
            if (state == STOP1 || state == STOP2) ferr <= ferr | ~bit_value;
        end
    end

    // The last stop decision is folded in directly because it arrives in the loading clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_bus.data_o       <= '0;
            rx_bus.valid_o      <= 1'b0;
            rx_bus.parity_err_o <= 1'b0;
            rx_bus.frame_err_o  <= 1'b0;
            rx_bus.break_o      <= 1'b0;
            rx_bus.overrun_o    <= 1'b0;
        end else if (load) begin
            rx_bus.data_o       <= sh;
            rx_bus.valid_o      <= 1'b1;
            rx_bus.parity_err_o <= par_en && (par_acc ^ (par_type == PARITY_ODD));
            rx_bus.frame_err_o  <= ferr | ~bit_value;
            rx_bus.break_o      <= ~(any_one | bit_value);
            rx_bus.overrun_o    <= 1'b0;
        end else if (done) begin
            rx_bus.overrun_o <= 1'b1;
        end else if (rx_bus.valid_o && rx_bus.ready_i) begin
            rx_bus.valid_o   <= 1'b0;
            rx_bus.overrun_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames at OVERSAMPLE=16 with one tick every 4 clk (64 clk per bit).
module tb_uart_rx_core;
    import uart_rx_pkg::*;
    logic clk = 1'b0;
    logic reset, rx_en_i, tick_i, rx_i, parity_en_i, parity_type_i, stop_bits_i, busy_o;
    logic [3:0] data_bits_i;
    logic [1:0] ph = 2'd0;
    int checks = 0;
    int failures = 0;
    int lat = 0;

    uart_rx_if #(.MAX_DATA_BITS(9)) rx_if ();
    uart_rx_core #(.OVERSAMPLE(16), .MAX_DATA_BITS(9)) dut (
        .clk(clk), .reset(reset), .rx_en_i(rx_en_i), .tick_i(tick_i), .rx_i(rx_i),
        .data_bits_i(data_bits_i), .parity_en_i(parity_en_i), .parity_type_i(parity_type_i),
        .stop_bits_i(stop_bits_i), .busy_o(busy_o), .rx_bus(rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ph + 2'd1;
    assign tick_i = ph == 2'd0;

    task automatic bit_time(input logic b, input int n);
        rx_i = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        while (ph != 2'd0) @(negedge clk);
    endtask

    task automatic cfg(input logic [3:0] nb, input logic pen, input logic pt, input logic sb);
        data_bits_i = nb;
        parity_en_i = pen;
        parity_type_i = pt;
        stop_bits_i = sb;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen, input logic pbit, input int nstop);
        align();
        bit_time(1'b0, 64);
        for (int i = 0; i < nb; i++) bit_time(d[i], 64);
        if (pen) bit_time(pbit, 64);
        repeat (nstop) bit_time(1'b1, 64);
    endtask

    task automatic accept();
        rx_if.ready_i = 1'b1;
        @(negedge clk);
        rx_if.ready_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_i = 1'b1; rx_en_i = 1'b1; rx_if.ready_i = 1'b0;
        cfg(4'd8, 1'b0, PARITY_EVEN, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (rx_if.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if ({rx_if.data_o, rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o, rx_if.overrun_o} !== 13'h0) begin
            failures++; $display("FAIL reset_outputs got=%h/%b%b%b%b exp=0", rx_if.data_o, rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o, rx_if.overrun_o);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_8n1();
        cfg(4'd8, 1'b0, PARITY_EVEN, 1'b0);
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1);
        checks++; if (rx_if.valid_o !== 1'b1) begin failures++; $display("FAIL 8n1_valid got=%b exp=1", rx_if.valid_o); end
        checks++; if (rx_if.data_o !== 9'h0A5) begin failures++; $display("FAIL 8n1_data got=%h exp=0a5", rx_if.data_o); end
        checks++; if ({rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o, rx_if.overrun_o} !== 4'b0) begin
            failures++; $display("FAIL 8n1_flags got=%b%b%b%b exp=0000", rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o, rx_if.overrun_o);
        end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL 8n1_busy got=%b exp=0", busy_o); end
        repeat (100) @(negedge clk);
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h0A5}) begin failures++; $display("FAIL 8n1_hold got=%b/%h exp=1/0a5", rx_if.valid_o, rx_if.data_o); end
        accept();
        checks++; if (rx_if.valid_o !== 1'b0) begin failures++; $display("FAIL 8n1_accept got=%b exp=0", rx_if.valid_o); end
    endtask

    task automatic test_parity();
        cfg(4'd9, 1'b1, PARITY_ODD, 1'b1);
        send_frame(9'h1FF, 9, 1'b1, 1'b1, 2);
        checks++; if (rx_if.valid_o !== 1'b1) begin failures++; $display("FAIL par_valid got=%b exp=1", rx_if.valid_o); end
        checks++; if (rx_if.data_o !== 9'h1FF) begin failures++; $display("FAIL par_data got=%h exp=1ff", rx_if.data_o); end
        checks++; if (rx_if.parity_err_o !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", rx_if.parity_err_o); end
        checks++; if (rx_if.frame_err_o !== 1'b0) begin failures++; $display("FAIL par_frame got=%b exp=0", rx_if.frame_err_o); end
        accept();
    endtask

    task automatic test_stop_bits();
        logic [8:0] d = 9'h055;
        cfg(4'd7, 1'b1, PARITY_EVEN, 1'b0);
        align();
        bit_time(1'b0, 64);
        for (int i = 0; i < 7; i++) bit_time(d[i], 64);
        bit_time(1'b0, 64);
        // Low for ticks 9..14 of the stop bit: only the last vote sample sees 0.
        bit_time(1'b1, 36);
        bit_time(1'b0, 24);
        bit_time(1'b1, 200);
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h055}) begin failures++; $display("FAIL stop_glitch_data got=%b/%h exp=1/055", rx_if.valid_o, rx_if.data_o); end
        checks++; if (rx_if.frame_err_o !== 1'b0) begin failures++; $display("FAIL stop_glitch_frame got=%b exp=0", rx_if.frame_err_o); end
        checks++; if (rx_if.parity_err_o !== 1'b0) begin failures++; $display("FAIL stop_glitch_parity got=%b exp=0", rx_if.parity_err_o); end
        accept();
        align();
        bit_time(1'b0, 64);
        for (int i = 0; i < 7; i++) bit_time(d[i], 64);
        bit_time(1'b0, 64);
        bit_time(1'b0, 64);
        bit_time(1'b1, 200);
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h055}) begin failures++; $display("FAIL stop_low_data got=%b/%h exp=1/055", rx_if.valid_o, rx_if.data_o); end
        checks++; if (rx_if.frame_err_o !== 1'b1) begin failures++; $display("FAIL stop_low_frame got=%b exp=1", rx_if.frame_err_o); end
        checks++; if (rx_if.break_o !== 1'b0) begin failures++; $display("FAIL stop_low_break got=%b exp=0", rx_if.break_o); end
        accept();
    endtask

    task automatic test_break();
        cfg(4'd8, 1'b0, PARITY_EVEN, 1'b0);
        align();
        bit_time(1'b0, 12 * 64);
        bit_time(1'b1, 200);
        checks++; if (rx_if.valid_o !== 1'b1) begin failures++; $display("FAIL brk_valid got=%b exp=1", rx_if.valid_o); end
        checks++; if (rx_if.break_o !== 1'b1) begin failures++; $display("FAIL brk_flag got=%b exp=1", rx_if.break_o); end
        checks++; if (rx_if.frame_err_o !== 1'b1) begin failures++; $display("FAIL brk_frame got=%b exp=1", rx_if.frame_err_o); end
        checks++; if (rx_if.data_o !== 9'h000) begin failures++; $display("FAIL brk_data got=%h exp=000", rx_if.data_o); end
        accept();
    endtask

    task automatic test_false_start();
        cfg(4'd8, 1'b0, PARITY_EVEN, 1'b0);
        align();
        bit_time(1'b0, 16);
        bit_time(1'b1, 300);
        checks++; if (rx_if.valid_o !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", rx_if.valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy_o); end
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1);
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h03C}) begin failures++; $display("FAIL glitch_next got=%b/%h exp=1/03c", rx_if.valid_o, rx_if.data_o); end
        checks++; if ({rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o} !== 3'b0) begin failures++; $display("FAIL glitch_next_flags got=%b%b%b exp=000", rx_if.parity_err_o, rx_if.frame_err_o, rx_if.break_o); end
    endtask

    task automatic test_abort();
        align();
        bit_time(1'b0, 64);
        bit_time(1'b1, 64);
        bit_time(1'b0, 30);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy_mid got=%b exp=1", busy_o); end
        rx_en_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        rx_en_i = 1'b1;
        bit_time(1'b1, 700);
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h03C}) begin failures++; $display("FAIL abort_held got=%b/%h exp=1/03c", rx_if.valid_o, rx_if.data_o); end
        checks++; if (rx_if.overrun_o !== 1'b0) begin failures++; $display("FAIL abort_overrun got=%b exp=0", rx_if.overrun_o); end
        accept();
    endtask

    task automatic test_clamp();
        cfg(4'd3, 1'b0, PARITY_EVEN, 1'b0);
        send_frame(9'h015, 5, 1'b0, 1'b0, 1);
        checks++; if ({rx_if.valid_o, rx_if.data_o, rx_if.frame_err_o} !== {1'b1, 9'h015, 1'b0}) begin
            failures++; $display("FAIL clamp_data got=%b/%h/%b exp=1/015/0", rx_if.valid_o, rx_if.data_o, rx_if.frame_err_o);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        cfg(4'd8, 1'b0, PARITY_EVEN, 1'b0);
        align();
        fork
            send_frame(9'h011, 8, 1'b0, 1'b0, 1);
            begin
                lat = 0;
                do begin @(negedge clk); lat++; end while (!rx_if.valid_o && lat < 2000);
            end
        join
        // Start at tick phase 0: start decided at clk 41, stop bit 9 bits later, load in that clk.
        checks++; if (lat !== 617) begin failures++; $display("FAIL b2b_latency got=%0d exp=617", lat); end
        send_frame(9'h022, 8, 1'b0, 1'b0, 1);
        send_frame(9'h033, 8, 1'b0, 1'b0, 1);
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h011}) begin failures++; $display("FAIL b2b_held got=%b/%h exp=1/011", rx_if.valid_o, rx_if.data_o); end
        checks++; if (rx_if.overrun_o !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", rx_if.overrun_o); end
        align();
        fork
            send_frame(9'h044, 8, 1'b0, 1'b0, 1);
            begin
                repeat (616) @(negedge clk);
                rx_if.ready_i = 1'b1;
                @(negedge clk);
                rx_if.ready_i = 1'b0;
            end
        join
        checks++; if ({rx_if.valid_o, rx_if.data_o} !== {1'b1, 9'h044}) begin failures++; $display("FAIL b2b_handoff got=%b/%h exp=1/044", rx_if.valid_o, rx_if.data_o); end
        checks++; if (rx_if.overrun_o !== 1'b0) begin failures++; $display("FAIL b2b_handoff_overrun got=%b exp=0", rx_if.overrun_o); end
    endtask

    task automatic test_reset_midframe();
        align();
        bit_time(1'b0, 64);
        bit_time(1'b1, 20);
        reset = 1'b1;
        #1;
        checks++; if ({busy_o, rx_if.valid_o} !== 2'b00) begin failures++; $display("FAIL rst_mid_ctrl got=%b%b exp=00", busy_o, rx_if.valid_o); end
        checks++; if (rx_if.data_o !== 9'h000) begin failures++; $display("FAIL rst_mid_data got=%h exp=000", rx_if.data_o); end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_bits();
        test_break();
        test_false_start();
        test_abort();
        test_clamp();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised next-generation UART receive engine. It oversamples the serial line at a configurable ratio and decides each bit by a three-sample majority vote. Frames of 5..MAX_DATA_BITS data bits are received with optional parity and 1 or 2 stop bits, and each received word is delivered with per-frame error flags through a valid/ready holding register. It sits between the line synchroniser and the receive FIFO of the UART peripheral.

## Interface
Parameters:
- OVERSAMPLE, 16: tick_i strobes per bit period; even, 8..32.
- MAX_DATA_BITS, 9: widest supported data field; 5..9.

Ports (one clock, `clk`; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- rx_en_i  in  1  receiver enable.
- tick_i  in  1  one-clk strobe at baud × OVERSAMPLE.
- rx_i  in  1  raw serial line, idle high; synchronised internally by the existing 2-flop `synchronizer`.
- data_bits_i  in  4  data bits per frame; legal range 5..MAX_DATA_BITS; values outside it clamp to the nearer limit.
- parity_en_i  in  1  parity bit present.
- parity_type_i  in  1  0 = even, 1 = odd.
- stop_bits_i  in  1  0 = one stop bit, 1 = two.
- data_o  out  MAX_DATA_BITS  received word, LSB-first on line, right-justified, upper bits zero.
- valid_o  out  1  holding register full.
- ready_i  in  1  consumer accepts word when valid_o & ready_i.
- parity_err_o  out  1  parity mismatch for held word.
- frame_err_o  out  1  a stop bit sampled 0 for held word.
- break_o  out  1  held frame was all-zero including parity and stop.
- overrun_o  out  1  at least one frame was dropped while the held word waited.
- busy_o  out  1  FSM not IDLE.

All outputs reset to 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE -> START: on a 1->0 edge of the synchronised line while rx_en_i = 1. The tick counter and bit counter clear in the same clk.
- Tick counter counts tick_i modulo OVERSAMPLE. The line is sampled at ticks M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the three samples, decided at tick M+1.
- START: majority 1 means a false start; return to IDLE with no output. Majority 0 goes to DATA.
- DATA: shift the decided bits in LSB-first. After data_bits_i bits, go to PARITY if parity_en_i = 1, else STOP1.
- PARITY: error = XOR of the data bits, the parity bit and parity_type_i. Go to STOP1.
- STOP1: majority 0 sets frame_err. Go to STOP2 if stop_bits_i = 1, else the frame completes.
- STOP2: majority 0 sets frame_err; the frame completes.
- Frame completion happens at the decision tick of the last stop bit. The FSM returns to IDLE there, so a start edge in the second half of the stop bit is honoured.
- Configuration inputs are captured at IDLE->START and held for the whole frame.
- break: every decided bit from START through the last stop bit is 0. break also sets frame_err.
- Holding register:
  - On completion, the word and flags load if valid_o = 0, or if valid_o & ready_i in the same clk (simultaneous handoff, no overrun).
  - Otherwise the new frame is discarded, the held word is kept, and overrun_o is set.
  - valid_o and overrun_o clear on handshake unless a new word loads in the same clk.
- rx_en_i falling mid-frame: abort to IDLE on the next clk with no load. The holding register is unaffected.
- reset mid-frame: immediate return to IDLE, all outputs 0.

## Timing
- Start detection: 2 clk synchroniser + 1 clk edge register.
- valid_o rises 1 clk after the clk carrying the last stop-bit decision tick.
- data_o and the flags are stable whenever valid_o = 1.
- busy_o falls in the same clk valid_o rises; both are registered.
- Decoding of consecutive back-to-back frames is error-free for baud mismatch of ±3% or less at OVERSAMPLE = 16.

## Structure
- Package `uart_rx_pkg` holds:
  - typedef enum rx_state_e {IDLE, START, DATA, PARITY, STOP1, STOP2}
  - MIN_DATA_BITS = 5
  - PARITY_EVEN / PARITY_ODD constants
- Sub-module `uart_rx_sampler` holds the tick counter, the three-sample capture and the majority vote. It outputs a one-clk `bit_valid` strobe with `bit_value`.
- The FSM, shifter, parity accumulator and holding register live in the top module.

## Test plan
- 8N1, OVERSAMPLE = 16, byte 0xA5 -> data_o = 0x0A5, valid_o = 1, all flags 0; hold ready_i = 0 and data_o holds.
- 9 data bits, odd parity, 2 stop bits, word 0x1FF sent with wrong parity -> data_o = 0x1FF, parity_err_o = 1.
- 7E1 with second-half stop bit forced 0 for 6 of 16 ticks (majority still 1) -> frame_err_o = 0. Forcing stop bit 0 for the whole bit -> frame_err_o = 1.
- Line low for 12 bit times -> break_o = 1, frame_err_o = 1, data_o = 0.
- 4-tick low glitch in IDLE -> false start, no valid_o. Then 0x3C sent -> received correctly.
- Three back-to-back frames 0x11/0x22/0x33 with ready_i = 0 -> held 0x11 with overrun_o = 1. Then ready_i pulse with frame 4 completing in the same clk -> 0x44 loads, overrun_o = 0.
